// File: rtl/bin2bcd_seq_pkg.sv
// rtl/bin2bcd_seq_pkg.sv - shared state codes and BCD adjust constants for bin2bcd_seq
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CONV = 2'b01
    } state_t;

    // A nibble at or above the threshold would carry past 9 once doubled.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// rtl/bin2bcd_seq_bcd_add3.sv - combinational "if >= 5 then add 3" cell for one BCD digit
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= BCD_ADJ_THRESH) ? nibble + BCD_ADJ_ADD : nibble;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter, one bit per clock
// Optional leading-zero blanking mask built when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [SCR_W-1:0]   scratch;
    logic [CNT_W-1:0]   count;
    logic               ovf_scr;

    logic [SCR_W-1:0]       adj;
    logic [SCR_W+BIN_W-1:0] shifted;
    logic [SCR_W-1:0]       scr_next;
    logic [BIN_W-1:0]       sh_next;
    logic                   ovf_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .nibble   (scratch[4*g +: 4]),
            .adjusted (adj[4*g +: 4])
        );
    end

    // A set MSB in the adjusted top digit is the bit lost by the shift.
    assign shifted  = {adj, shreg} << 1;
    assign scr_next = shifted[SCR_W+BIN_W-1 -: SCR_W];
    assign sh_next  = shifted[BIN_W-1:0];
    assign ovf_next = ovf_scr | adj[SCR_W-1];

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;

    always_comb begin
        logic all_zero;
        blank_next = '0;
        all_zero   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero      = all_zero && (scr_next[4*k +: 4] == 4'd0);
            blank_next[k] = all_zero;
        end
        if (ovf_next) begin
            blank_next = '0;
        end
    end
`else
    assign blank_o = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
            ovf_scr <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            bcd_o   <= '0;
            ovf_o   <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_o <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        shreg   <= bin_i;
                        scratch <= '0;
                        count   <= CNT_W'(BIN_W);
                        ovf_scr <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    shreg   <= sh_next;
                    scratch <= scr_next;
                    ovf_scr <= ovf_next;
                    count   <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        bcd_o  <= scr_next;
                        ovf_o  <= ovf_next;
`ifdef BIN2BCD_BLANK_EN
                        blank_o <= blank_next;
`endif
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - self-checking bench for bin2bcd_seq (3-digit and 2-digit instances)
module tb_bin2bcd_seq;

`ifdef BIN2BCD_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
    logic [1:0]  blank2;

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .bin_i(bin),
        .busy_o(busy3), .done_o(done3), .bcd_o(bcd3), .ovf_o(ovf3), .blank_o(blank3)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .bin_i(bin),
        .busy_o(busy2), .done_o(done2), .bcd_o(bcd2), .ovf_o(ovf2), .blank_o(blank2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decimal digits by division, blanking by magnitude.
    function automatic logic [11:0] ref_bcd3(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] ref_bcd2(input int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] ref_blank3(input int v);
        if (!BLANK_EN || v > 999) return 3'b000;
        return {v < 100, v < 10, 1'b0};
    endfunction

    function automatic logic [1:0] ref_blank2(input int v);
        if (!BLANK_EN || v > 99) return 2'b00;
        return {v < 10, 1'b0};
    endfunction

    // Starts one conversion and returns at the negedge where done is seen (lat = -1 on timeout).
    task automatic run_conv(input logic [7:0] v, output int lat, output int busy_cnt, output bit held);
        logic [11:0] prev;
        @(negedge clk);
        prev     = bcd3;
        start    = 1'b1;
        bin      = v;
        lat      = -1;
        busy_cnt = 0;
        held     = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            bin   = 8'($urandom);
            if (done3) begin
                lat = i;
                break;
            end
            if (busy3) busy_cnt++;
            if (bcd3 !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy3 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy3 got %b want 0", busy3); end
        n_checks++; if (done3 !== 1'b0)   begin n_fail++; $display("FAIL reset_done3 got %b want 0", done3); end
        n_checks++; if (bcd3 !== 12'h000) begin n_fail++; $display("FAIL reset_bcd3 got %h want 000", bcd3); end
        n_checks++; if (ovf3 !== 1'b0)    begin n_fail++; $display("FAIL reset_ovf3 got %b want 0", ovf3); end
        n_checks++; if (blank3 !== 3'b0)  begin n_fail++; $display("FAIL reset_blank3 got %b want 000", blank3); end
        n_checks++; if (bcd2 !== 8'h00)   begin n_fail++; $display("FAIL reset_bcd2 got %h want 00", bcd2); end
        n_checks++; if (busy2 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy2 got %b want 0", busy2); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy3 !== 1'b0)   begin n_fail++; $display("FAIL idle_busy3 got %b want 0", busy3); end
    endtask

    task automatic test_zero_latency;
        int lat, bc;
        bit held;
        run_conv(8'd0, lat, bc, held);
        n_checks++; if (lat != 9)         begin n_fail++; $display("FAIL zero_latency got %0d want 9", lat); end
        n_checks++; if (bc != 8)          begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 8", bc); end
        n_checks++; if (bcd3 !== 12'h000) begin n_fail++; $display("FAIL zero_bcd3 got %h want 000", bcd3); end
        n_checks++; if (ovf3 !== 1'b0)    begin n_fail++; $display("FAIL zero_ovf3 got %b want 0", ovf3); end
        n_checks++; if (busy3 !== 1'b0)   begin n_fail++; $display("FAIL zero_busy_at_done got %b want 0", busy3); end
        @(negedge clk);
        n_checks++; if (done3 !== 1'b0)   begin n_fail++; $display("FAIL zero_done_width got %b want 0", done3); end
    endtask

    task automatic test_directed;
        int vals[3] = '{255, 99, 100};
        int lat, bc;
        bit held;
        foreach (vals[i]) begin
            run_conv(8'(vals[i]), lat, bc, held);
            n_checks++; if (lat != 9) begin n_fail++; $display("FAIL dir_latency v=%0d got %0d want 9", vals[i], lat); end
            n_checks++; if (bcd3 !== ref_bcd3(vals[i])) begin n_fail++; $display("FAIL dir_bcd3 v=%0d got %h want %h", vals[i], bcd3, ref_bcd3(vals[i])); end
            n_checks++; if (ovf3 !== 1'b0) begin n_fail++; $display("FAIL dir_ovf3 v=%0d got %b want 0", vals[i], ovf3); end
            n_checks++; if (ovf2 !== (vals[i] > 99)) begin n_fail++; $display("FAIL dir_ovf2 v=%0d got %b want %b", vals[i], ovf2, vals[i] > 99); end
            if (vals[i] <= 99) begin
                n_checks++; if (bcd2 !== ref_bcd2(vals[i])) begin n_fail++; $display("FAIL dir_bcd2 v=%0d got %h want %h", vals[i], bcd2, ref_bcd2(vals[i])); end
            end
        end
    endtask

    task automatic test_random;
        int v, lat, bc;
        bit held;
        logic [11:0] prev;
        for (int n = 0; n < 24; n++) begin
            v    = int'($urandom_range(0, 255));
            prev = bcd3;
            run_conv(8'(v), lat, bc, held);
            n_checks++; if (lat != 9) begin n_fail++; $display("FAIL rnd_latency v=%0d got %0d want 9", v, lat); end
            n_checks++; if (!held) begin n_fail++; $display("FAIL rnd_hold v=%0d previous result %h not held", v, prev); end
            n_checks++; if (bcd3 !== ref_bcd3(v)) begin n_fail++; $display("FAIL rnd_bcd3 v=%0d got %h want %h", v, bcd3, ref_bcd3(v)); end
            n_checks++; if (ovf3 !== (v > 999)) begin n_fail++; $display("FAIL rnd_ovf3 v=%0d got %b want %b", v, ovf3, v > 999); end
            n_checks++; if (blank3 !== ref_blank3(v)) begin n_fail++; $display("FAIL rnd_blank3 v=%0d got %b want %b", v, blank3, ref_blank3(v)); end
            n_checks++; if (ovf2 !== (v > 99)) begin n_fail++; $display("FAIL rnd_ovf2 v=%0d got %b want %b", v, ovf2, v > 99); end
            n_checks++; if (blank2 !== ref_blank2(v)) begin n_fail++; $display("FAIL rnd_blank2 v=%0d got %b want %b", v, blank2, ref_blank2(v)); end
            if (v <= 99) begin
                n_checks++; if (bcd2 !== ref_bcd2(v)) begin n_fail++; $display("FAIL rnd_bcd2 v=%0d got %h want %h", v, bcd2, ref_bcd2(v)); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int ndone = 0, first_lat = -1, second_lat = -1, t1 = 0;
        logic [11:0] first_bcd = 12'hxxx, second_bcd = 12'hxxx;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd37;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (i == 3) begin
                start = 1'b1;
                bin   = 8'd200;
            end
            if (done3) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = i;
                    first_bcd = bcd3;
                    t1        = i;
                    start     = 1'b1;
                    bin       = 8'd200;
                end else begin
                    second_lat = i - t1;
                    second_bcd = bcd3;
                    break;
                end
            end
        end
        start = 1'b0;
        n_checks++; if (first_lat != 9)      begin n_fail++; $display("FAIL b2b_first_latency got %0d want 9", first_lat); end
        n_checks++; if (first_bcd !== 12'h037) begin n_fail++; $display("FAIL b2b_first_bcd got %h want 037", first_bcd); end
        n_checks++; if (second_lat != 9)     begin n_fail++; $display("FAIL b2b_second_latency got %0d want 9", second_lat); end
        n_checks++; if (second_bcd !== 12'h200) begin n_fail++; $display("FAIL b2b_second_bcd got %h want 200", second_bcd); end
    endtask

    task automatic test_reset_abort;
        int lat, bc, spurious = 0;
        bit held;
        run_conv(8'd123, lat, bc, held);
        n_checks++; if (bcd3 !== 12'h123) begin n_fail++; $display("FAIL abort_pre_bcd3 got %h want 123", bcd3); end
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd45;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bcd3 !== 12'h000) begin n_fail++; $display("FAIL abort_bcd3 got %h want 000", bcd3); end
        n_checks++; if (busy3 !== 1'b0)   begin n_fail++; $display("FAIL abort_busy3 got %b want 0", busy3); end
        n_checks++; if (ovf3 !== 1'b0)    begin n_fail++; $display("FAIL abort_ovf3 got %b want 0", ovf3); end
        n_checks++; if (blank3 !== 3'b0)  begin n_fail++; $display("FAIL abort_blank3 got %b want 000", blank3); end
        n_checks++; if (bcd2 !== 8'h00)   begin n_fail++; $display("FAIL abort_bcd2 got %h want 00", bcd2); end
        repeat (3) begin
            @(negedge clk);
            if (done3 || done2) spurious++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done3 || done2 || busy3) spurious++;
        end
        n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL abort_no_done got %0d done/busy cycles want 0", spurious); end
        run_conv(8'd45, lat, bc, held);
        n_checks++; if (lat != 9)         begin n_fail++; $display("FAIL abort_post_latency got %0d want 9", lat); end
        n_checks++; if (bcd3 !== 12'h045) begin n_fail++; $display("FAIL abort_post_bcd3 got %h want 045", bcd3); end
    endtask

    task automatic test_blank;
        int         vals[4]  = '{7, 0, 40, 205};
        logic [2:0] want3[4] = '{3'b110, 3'b110, 3'b100, 3'b000};
        logic [1:0] want2[4] = '{2'b10, 2'b10, 2'b00, 2'b00};
        int lat, bc;
        bit held;
        foreach (vals[i]) begin
            run_conv(8'(vals[i]), lat, bc, held);
            n_checks++;
            if (blank3 !== (want3[i] & {3{BLANK_EN}})) begin
                n_fail++; $display("FAIL blank3 v=%0d got %b want %b", vals[i], blank3, want3[i] & {3{BLANK_EN}});
            end
            n_checks++;
            if (blank2 !== (want2[i] & {2{BLANK_EN}})) begin
                n_fail++; $display("FAIL blank2 v=%0d got %b want %b", vals[i], blank2, want2[i] & {2{BLANK_EN}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
